// File: rtl/and_gate_pkg.sv
// rtl/and_gate_pkg.sv - shared defaults for the and_gate slice
// Purpose : default operand width and rise-counter width used by and_gate
//           and its saturating counter.
// Contents: DEFAULT_WIDTH, DEFAULT_CNT_W
package and_gate_pkg;

    // Operand / result width when the instantiator does not override it.
    localparam int DEFAULT_WIDTH = 1;

    // Width of the all_q rising-edge counter.
    localparam int DEFAULT_CNT_W = 8;

endpackage : and_gate_pkg

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous active-high reset
// Purpose : counts cycles where inc is high; sticks at all-ones instead of wrapping.
// Ports   :
//   clk   in  1      rising-edge clock
//   rst   in  1      synchronous active-high reset, clears count
//   inc   in  1      increment request for this edge
//   count out CNT_W  current count
module sat_counter
    import and_gate_pkg::*;
#(
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Hold at the maximum value once reached so a long run of events never
    // reads back as a small number.
    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule : sat_counter

// File: rtl/and_gate.sv
// rtl/and_gate.sv - bitwise AND with registered copy, all-ones flag and rise counter
// Purpose : out is the pure combinational a & b; out_q and all_q are its
//           registered copy and registered reduction-AND; rise_cnt counts
//           0->1 transitions of all_q, saturating.
// Ports   :
//   clk      in  1      rising-edge clock
//   rst      in  1      synchronous active-high reset
//   a, b     in  WIDTH  operands
//   out      out WIDTH  a & b, no clock latency
//   out_q    out WIDTH  a & b captured on the last edge
//   all_q    out 1      &(a & b) captured on the last edge
//   rise_cnt out CNT_W  number of all_q rising edges since reset
module and_gate
    import and_gate_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = DEFAULT_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] out_q,
    output logic             all_q,
    output logic [CNT_W-1:0] rise_cnt
);

    logic [WIDTH-1:0] out_d;
    logic             all_d;
    logic             rise;

    // Purely combinational; deliberately independent of clk and rst so it
    // keeps tracking the operands even while reset is held.
    assign out = a & b;

    always_comb begin
        out_d = out;
        all_d = &out;
        // A rise is judged against the value all_q holds now, so the first
        // edge after reset counts when the operands are already all-ones.
        rise  = ~all_q & all_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_q <= '0;
            all_q <= 1'b0;
        end else begin
            out_q <= out_d;
            all_q <= all_d;
        end
    end

    // The counter applies its own reset, which overrides rise on the same edge.
    sat_counter #(
        .CNT_W (CNT_W)
    ) u_rise_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (rise),
        .count (rise_cnt)
    );

endmodule : and_gate

// File: tb/tb_and_gate.sv
// tb/tb_and_gate.sv - directed self-checking bench for and_gate
module tb_and_gate;

    typedef struct {
        logic a;
        logic b;
        logic exp;
    } vec1_t;

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] exp;
    } vec4_t;

    logic       clk = 1'b0;
    logic       clk_en = 1'b0;
    logic       rst = 1'b0;

    logic       a1 = 1'b0;
    logic       b1 = 1'b0;
    logic [3:0] a4 = 4'h0;
    logic [3:0] b4 = 4'h0;

    logic       out1, out_q1, all_q1;
    logic [7:0] cnt1;
    logic       out_s, out_q_s, all_q_s;
    logic [1:0] cnt_s;
    logic [3:0] out4, out_q4;
    logic       all_q4;
    logic [7:0] cnt4;

    int checks = 0;
    int errors = 0;

    and_gate #(.WIDTH(1), .CNT_W(8)) u_dut1 (
        .clk(clk), .rst(rst), .a(a1), .b(b1),
        .out(out1), .out_q(out_q1), .all_q(all_q1), .rise_cnt(cnt1)
    );

    and_gate #(.WIDTH(1), .CNT_W(2)) u_dut_sat (
        .clk(clk), .rst(rst), .a(a1), .b(b1),
        .out(out_s), .out_q(out_q_s), .all_q(all_q_s), .rise_cnt(cnt_s)
    );

    and_gate #(.WIDTH(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .a(a4), .b(b4),
        .out(out4), .out_q(out_q4), .all_q(all_q4), .rise_cnt(cnt4)
    );

    initial begin
        forever begin
            #5;
            if (clk_en) clk = ~clk;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog act=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    vec1_t v1[4];
    vec4_t v4[6];

    logic       exp_out_q;
    logic       exp_all;
    int         exp_cnt8;
    int         exp_cnt2;

    initial begin
        v1[0] = '{1'b0, 1'b0, 1'b0};
        v1[1] = '{1'b0, 1'b1, 1'b0};
        v1[2] = '{1'b1, 1'b0, 1'b0};
        v1[3] = '{1'b1, 1'b1, 1'b1};

        v4[0] = '{4'b1111, 4'b1011, 4'b1011};
        v4[1] = '{4'b1010, 4'b0101, 4'b0000};
        v4[2] = '{4'b1100, 4'b0110, 4'b0100};
        v4[3] = '{4'b1111, 4'b1111, 4'b1111};
        v4[4] = '{4'b0000, 4'b1111, 4'b0000};
        v4[5] = '{4'b0111, 4'b1110, 4'b0110};

        // Combinational path with the clock stopped.
        for (int i = 0; i < 4; i++) begin
            a1 = v1[i].a;
            b1 = v1[i].b;
            #1;
            chk($sformatf("comb_w1[%0d]", i), 32'(out1), 32'(v1[i].exp));
            #9;
        end
        for (int i = 0; i < 6; i++) begin
            a4 = v4[i].a;
            b4 = v4[i].b;
            #1;
            chk($sformatf("comb_w4[%0d]", i), 32'(out4), 32'(v4[i].exp));
            #9;
        end

        // Reset for two edges with all-ones operands, then release.
        a1 = 1'b1; b1 = 1'b1; a4 = 4'hF; b4 = 4'hF;
        rst = 1'b1;
        clk_en = 1'b1;
        tick();
        tick();
        chk("rst_out_q", 32'(out_q1), 32'(0));
        chk("rst_all_q", 32'(all_q1), 32'(0));
        chk("rst_cnt", 32'(cnt1), 32'(0));
        chk("rst_cnt_sat", 32'(cnt_s), 32'(0));
        chk("rst_out_q4", 32'(out_q4), 32'(0));
        chk("rst_out_live", 32'(out1), 32'(1));
        rst = 1'b0;
        tick();
        chk("first_out_q", 32'(out_q1), 32'(1));
        chk("first_all_q", 32'(all_q1), 32'(1));
        chk("first_rise_cnt", 32'(cnt1), 32'(1));
        chk("first_all_q4", 32'(all_q4), 32'(1));
        chk("first_cnt4", 32'(cnt4), 32'(1));

        // Toggle b every two cycles, five high phases.
        rst = 1'b1; a1 = 1'b1; b1 = 1'b0; a4 = 4'h0; b4 = 4'h0;
        tick();
        rst = 1'b0;
        exp_out_q = 1'b0; exp_all = 1'b0; exp_cnt8 = 0; exp_cnt2 = 0;
        for (int p = 0; p < 5; p++) begin
            for (int c = 0; c < 4; c++) begin
                b1 = (c < 2);
                #1;
                chk("tog_out_live", 32'(out1), 32'(a1 & b1));
                chk("tog_out_q_hold", 32'(out_q1), 32'(exp_out_q));
                tick();
                if (!exp_all && (a1 & b1)) begin
                    exp_cnt8++;
                    if (exp_cnt2 < 3) exp_cnt2++;
                end
                exp_out_q = a1 & b1;
                exp_all = a1 & b1;
                chk("tog_out_q", 32'(out_q1), 32'(exp_out_q));
                chk("tog_all_q", 32'(all_q1), 32'(exp_all));
                chk("tog_cnt", 32'(cnt1), 32'(exp_cnt8));
                chk("tog_cnt_sat", 32'(cnt_s), 32'(exp_cnt2));
            end
        end
        chk("tog_final_cnt", 32'(cnt1), 32'(5));
        chk("sat_final_cnt", 32'(cnt_s), 32'(3));
        b1 = 1'b1;
        tick();
        b1 = 1'b0;
        tick();
        b1 = 1'b1;
        tick();
        chk("sat_hold", 32'(cnt_s), 32'(3));

        // Four-bit: partial match, then full match.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a4 = 4'b1111; b4 = 4'b1011;
        #1;
        chk("w4_out_partial", 32'(out4), 32'(4'b1011));
        tick();
        chk("w4_all_q_partial", 32'(all_q4), 32'(0));
        chk("w4_out_q_partial", 32'(out_q4), 32'(4'b1011));
        b4 = 4'b1111;
        tick();
        chk("w4_all_q_full", 32'(all_q4), 32'(1));
        chk("w4_cnt_full", 32'(cnt4), 32'(1));

        // Reset mid-operation with all_q=1 and rise_cnt=2.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        a1 = 1'b1; b1 = 1'b1;
        tick();
        b1 = 1'b0;
        tick();
        b1 = 1'b1;
        tick();
        chk("pre_rst_all_q", 32'(all_q1), 32'(1));
        chk("pre_rst_cnt", 32'(cnt1), 32'(2));
        rst = 1'b1;
        tick();
        chk("mid_rst_out_q", 32'(out_q1), 32'(0));
        chk("mid_rst_all_q", 32'(all_q1), 32'(0));
        chk("mid_rst_cnt", 32'(cnt1), 32'(0));
        chk("mid_rst_out_live", 32'(out1), 32'(1));
        b1 = 1'b0;
        #1;
        chk("mid_rst_out_follow", 32'(out1), 32'(0));
        rst = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_and_gate

// File: doc/and_gate.md
AND_GATE -- requirements
Module: and_gate

Interface
REQ-001 Parameter WIDTH, default 1, bit width of operands a, b and result out.
REQ-002 Parameter CNT_W, default 8, bit width of the rise counter.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rst  input  1  reset, synchronous, active-high.
REQ-005 Port a  input  WIDTH  first operand.
REQ-006 Port b  input  WIDTH  second operand.
REQ-007 Port out  output  WIDTH  combinational bitwise AND of a and b.
REQ-008 Port out_q  output  WIDTH  registered copy of out.
REQ-009 Port all_q  output  1  registered reduction-AND of out (1 when every bit of a&b is 1).
REQ-010 Port rise_cnt  output  CNT_W  count of rising edges of all_q.

Function
REQ-011 out SHALL equal a & b bitwise at all times, with zero clock latency and no dependence on clk or rst.
REQ-012 Truth table per bit SHALL be: 0,0->0; 0,1->0; 1,0->0; 1,1->1.
REQ-013 out SHALL propagate X/Z on an input as standard Verilog & semantics (0 & X = 0; 1 & X = X).
REQ-014 out_q SHALL load a & b on every rising clk edge when rst is low (latency 1 cycle).
REQ-015 all_q SHALL load &(a & b) on every rising clk edge when rst is low (latency 1 cycle).
REQ-016 rise_cnt SHALL increment by 1 on a clk edge where all_q is currently 0 and the next all_q value is 1.
REQ-017 rise_cnt SHALL saturate at 2^CNT_W-1 and hold; it SHALL not wrap to 0.
REQ-018 Input changes between clock edges SHALL affect only out, never out_q, all_q or rise_cnt until the next edge.

Reset
REQ-019 On a rising clk edge with rst high, out_q SHALL become 0, all_q SHALL become 0, rise_cnt SHALL become 0.
REQ-020 Reset SHALL take priority over loading and counting on the same edge.
REQ-021 A rising edge at the first clock edge after rst deasserts SHALL be counted if a&b is all-ones, since all_q was 0.
REQ-022 Reset asserted mid-operation SHALL clear all registered state within one edge; out SHALL remain a & b throughout reset.
REQ-023 Before the first reset edge, registered outputs are undefined. No initial values SHALL be relied upon.

Structure
REQ-024 Default WIDTH and CNT_W constants SHALL live in a shared package and_gate_pkg.
REQ-025 The saturating counter SHALL be a single sub-module sat_counter (inputs clk, rst, inc; output count).
REQ-026 The combinational AND path SHALL contain no storage elements.

Verification
REQ-027 WIDTH=1, no clock: apply a,b = 00,01,10,11 with 10 time units each -> out = 0,0,0,1, updating immediately on each change.
REQ-028 WIDTH=1, rst high for 2 edges then low, a=1,b=1 -> out_q=1, all_q=1 after 1 edge, rise_cnt=1.
REQ-029 Toggle b 0/1 every 2 cycles with a=1, for 5 high phases -> rise_cnt=5, and out_q follows out delayed by 1 cycle.
REQ-030 CNT_W=2, 5 rising edges of all_q -> rise_cnt saturates at 3 and holds.
REQ-031 WIDTH=4, a=4'b1111, b=4'b1011 -> out=4'b1011, all_q=0 after the next edge; b=4'b1111 -> all_q=1 after the next edge.
REQ-032 Assert rst while all_q=1 and rise_cnt=2 -> all registered outputs are 0 after one edge, and out still equals a & b.
